// File: rtl/mock_channel_cu_pkg.sv
// Shared types and constants for the mock bus-and-tag control unit.
// The state enum, the ending-status bytes and the command-class decode live here.
package mock_channel_cu_pkg;

  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_ADDR        = 4'd1,
    ST_CMD_WAIT    = 4'd2,
    ST_INIT_STATUS = 4'd3,
    ST_INIT_DROP   = 4'd4,
    ST_DATA        = 4'd5,
    ST_DATA_DROP   = 4'd6,
    ST_STOP_WAIT   = 4'd7,
    ST_END_STATUS  = 4'd8,
    ST_END_DROP    = 4'd9,
    ST_DISCONNECT  = 4'd10
  } state_t;

  typedef enum logic [2:0] {
    CLS_TEST    = 3'd0,
    CLS_CONTROL = 3'd1,
    CLS_READ    = 3'd2,
    CLS_WRITE   = 3'd3,
    CLS_NONE    = 3'd4
  } cmd_class_t;

  localparam logic [7:0] STAT_BUSY  = 8'h10;
  localparam logic [7:0] STAT_CE_DE = 8'h0C;
  localparam logic [7:0] STAT_ZERO  = 8'h00;

  // Classify a command byte; control (xx11) wins over write (xxx1).
  function automatic cmd_class_t cmd_class(input logic [7:0] c);
    cmd_class_t r;
    if (c == 8'h00)                            r = CLS_TEST;
    else if (c[1:0] == 2'b11)                  r = CLS_CONTROL;
    else if (c[1:0] == 2'b10 || c[3:0] == 4'b0100) r = CLS_READ;
    else if (c[0])                             r = CLS_WRITE;
    else                                       r = CLS_NONE;
    return r;
  endfunction

endpackage

// File: rtl/mock_channel_cu_chain.sv
// Select daisy-chain passthrough: while the control unit is idle, selection
// is forwarded to the next unit and its select-in returned to the channel.
// Both directions are registered; outside IDLE the chain is blocked.
module mock_channel_cu_chain (
  input  logic aclk,
  input  logic aresetn,
  input  logic idle,
  input  logic b_select_out,
  input  logic b_hold_out,
  input  logic a_select_in,
  output logic a_select_out,
  output logic b_select_in
);

  // Registered passthrough gated by the idle state.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      a_select_out <= 1'b0;
      b_select_in  <= 1'b0;
    end else begin
      a_select_out <= idle & b_select_out & b_hold_out;
      b_select_in  <= idle & a_select_in;
    end
  end

endmodule

// File: rtl/mock_channel_cu.sv
// Mock parallel-channel control unit answering one device address.
// Runs initial selection, command acceptance, byte-interlocked data and
// ending status. Every inbound tag is raised, held until the channel's
// response tag rises, dropped, and the next step waits for the response
// tag to fall. All outputs are registered.
// Optional watchdog: define MOCK_CHANNEL_CU_TIMEOUT_EN.
module mock_channel_cu
  import mock_channel_cu_pkg::*;
#(
  parameter logic [7:0] DEV_ADDR       = 8'h10,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic [7:0] b_bus_out,
  output logic [7:0] b_bus_in,
  input  logic       b_operational_out,
  input  logic       b_hold_out,
  input  logic       b_select_out,
  input  logic       b_address_out,
  input  logic       b_command_out,
  input  logic       b_service_out,
  input  logic       b_suppress_out,
  output logic       b_operational_in,
  output logic       b_request_in,
  output logic       b_select_in,
  output logic       b_address_in,
  output logic       b_status_in,
  output logic       b_service_in,
  output logic       a_select_out,
  input  logic       a_select_in,
  input  logic       mock_busy,
  input  logic [7:0] mock_limit,
  output logic [7:0] command,
  output logic [7:0] count,
  output state_t     dbg_state
);

  state_t     state_q, state_d;
  logic       op_in_q, op_in_d;
  logic       addr_in_q, addr_in_d;
  logic       stat_in_q, stat_in_d;
  logic       svc_in_q, svc_in_d;
  logic [7:0] bus_in_q, bus_in_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] count_q, count_d;
  logic       busy_q, busy_d;
  logic       abort;
  cmd_class_t cls;

  // Suppress-out has no meaning for this unit.
  logic unused_inputs;
  assign unused_inputs = b_suppress_out ^ (TIMEOUT_CYCLES == 0);

  assign cls = cmd_class(cmd_q);

`ifdef MOCK_CHANNEL_CU_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_q;

  // Watchdog: restarts on every state change, counts while not idle.
  always_ff @(posedge aclk) begin
    if (!aresetn || state_d != state_q || state_q == ST_IDLE) to_cnt_q <= '0;
    else                                                      to_cnt_q <= to_cnt_q + 1'b1;
  end

  assign abort = (state_q != ST_IDLE) &&
                 (!b_operational_out || to_cnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
  assign abort = (state_q != ST_IDLE) && !b_operational_out;
`endif

  // Next-state and next-output logic; registers hold unless a step fires.
  always_comb begin
    state_d   = state_q;
    op_in_d   = op_in_q;
    addr_in_d = addr_in_q;
    stat_in_d = stat_in_q;
    svc_in_d  = svc_in_q;
    bus_in_d  = bus_in_q;
    cmd_d     = cmd_q;
    count_d   = count_q;
    busy_d    = busy_q;

    if (abort) begin
      state_d   = ST_IDLE;
      op_in_d   = 1'b0;
      addr_in_d = 1'b0;
      stat_in_d = 1'b0;
      svc_in_d  = 1'b0;
      bus_in_d  = 8'h00;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (b_operational_out && b_address_out && b_select_out &&
              b_hold_out && b_bus_out == DEV_ADDR) begin
            state_d   = ST_ADDR;
            op_in_d   = 1'b1;
            addr_in_d = 1'b1;
            bus_in_d  = DEV_ADDR;
          end
        end
        ST_ADDR: begin
          if (b_command_out) begin
            state_d   = ST_CMD_WAIT;
            cmd_d     = b_bus_out;
            count_d   = 8'h00;
            addr_in_d = 1'b0;
            bus_in_d  = 8'h00;
          end
        end
        ST_CMD_WAIT: begin
          if (!b_command_out) begin
            state_d   = ST_INIT_STATUS;
            stat_in_d = 1'b1;
            busy_d    = mock_busy;
            bus_in_d  = mock_busy ? STAT_BUSY : STAT_ZERO;
          end
        end
        ST_INIT_STATUS: begin
          if (b_service_out) begin
            state_d   = ST_INIT_DROP;
            stat_in_d = 1'b0;
            bus_in_d  = 8'h00;
          end
        end
        ST_INIT_DROP: begin
          if (!b_service_out) begin
            if (busy_q || cls == CLS_TEST) begin
              state_d = ST_DISCONNECT;
              op_in_d = 1'b0;
            end else if (cls == CLS_CONTROL) begin
              state_d   = ST_END_STATUS;
              stat_in_d = 1'b1;
              bus_in_d  = STAT_CE_DE;
            end else begin
              state_d = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (!svc_in_q) begin
            if (count_q == mock_limit) begin
              state_d   = ST_END_STATUS;
              stat_in_d = 1'b1;
              bus_in_d  = STAT_CE_DE;
            end else begin
              svc_in_d = 1'b1;
              bus_in_d = (cls == CLS_READ) ? count_q : 8'h00;
            end
          end else if (b_command_out) begin
            state_d  = ST_STOP_WAIT;
            svc_in_d = 1'b0;
            bus_in_d = 8'h00;
          end else if (b_service_out) begin
            state_d  = ST_DATA_DROP;
            svc_in_d = 1'b0;
            bus_in_d = 8'h00;
            count_d  = count_q + 8'd1;
          end
        end
        ST_DATA_DROP: begin
          if (!b_service_out) state_d = ST_DATA;
        end
        ST_STOP_WAIT: begin
          if (!b_command_out) begin
            state_d   = ST_END_STATUS;
            stat_in_d = 1'b1;
            bus_in_d  = STAT_CE_DE;
          end
        end
        ST_END_STATUS: begin
          if (b_service_out) begin
            state_d   = ST_END_DROP;
            stat_in_d = 1'b0;
            bus_in_d  = 8'h00;
          end
        end
        ST_END_DROP: begin
          if (!b_service_out) begin
            state_d = ST_DISCONNECT;
            op_in_d = 1'b0;
          end
        end
        ST_DISCONNECT: begin
          op_in_d  = 1'b0;
          bus_in_d = 8'h00;
          if (!b_select_out) state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= ST_IDLE;
      op_in_q   <= 1'b0;
      addr_in_q <= 1'b0;
      stat_in_q <= 1'b0;
      svc_in_q  <= 1'b0;
      bus_in_q  <= 8'h00;
      cmd_q     <= 8'h00;
      count_q   <= 8'h00;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_in_q   <= op_in_d;
      addr_in_q <= addr_in_d;
      stat_in_q <= stat_in_d;
      svc_in_q  <= svc_in_d;
      bus_in_q  <= bus_in_d;
      cmd_q     <= cmd_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
    end
  end

  mock_channel_cu_chain u_chain (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .idle         (state_q == ST_IDLE),
    .b_select_out (b_select_out),
    .b_hold_out   (b_hold_out),
    .a_select_in  (a_select_in),
    .a_select_out (a_select_out),
    .b_select_in  (b_select_in)
  );

  assign b_operational_in = op_in_q;
  assign b_address_in     = addr_in_q;
  assign b_status_in      = stat_in_q;
  assign b_service_in     = svc_in_q;
  assign b_request_in     = 1'b0;
  assign b_bus_in         = bus_in_q;
  assign command          = cmd_q;
  assign count            = count_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_mock_channel_cu.sv
// Directed bench for mock_channel_cu: acts as the channel, walks through
// selection, command, data, stop and selective reset, and checks responses.
module tb_mock_channel_cu;
  import mock_channel_cu_pkg::*;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic [7:0] b_bus_out = 8'h00;
  logic [7:0] b_bus_in;
  logic       b_operational_out = 1'b0, b_hold_out = 1'b0, b_select_out = 1'b0;
  logic       b_address_out = 1'b0, b_command_out = 1'b0, b_service_out = 1'b0;
  logic       b_suppress_out = 1'b0;
  logic       b_operational_in, b_request_in, b_select_in, b_address_in;
  logic       b_status_in, b_service_in;
  logic       a_select_out;
  logic       a_select_in = 1'b0;
  logic       mock_busy = 1'b0;
  logic [7:0] mock_limit = 8'h00;
  logic [7:0] command, count;
  state_t     dbg_state;

  int n_assert = 0;
  int n_fail   = 0;

  // Clock and reset block.
  always #5 aclk = ~aclk;

  mock_channel_cu #(.DEV_ADDR(8'h10), .TIMEOUT_CYCLES(1024)) dut (
    .aclk (aclk), .aresetn (aresetn),
    .b_bus_out (b_bus_out), .b_bus_in (b_bus_in),
    .b_operational_out (b_operational_out), .b_hold_out (b_hold_out),
    .b_select_out (b_select_out), .b_address_out (b_address_out),
    .b_command_out (b_command_out), .b_service_out (b_service_out),
    .b_suppress_out (b_suppress_out),
    .b_operational_in (b_operational_in), .b_request_in (b_request_in),
    .b_select_in (b_select_in), .b_address_in (b_address_in),
    .b_status_in (b_status_in), .b_service_in (b_service_in),
    .a_select_out (a_select_out), .a_select_in (a_select_in),
    .mock_busy (mock_busy), .mock_limit (mock_limit),
    .command (command), .count (count), .dbg_state (dbg_state)
  );

  // Advance one clock; sample and drive 1 ns after the rising edge.
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // 0=operational_in 1=address_in 2=status_in 3=service_in
  function automatic logic tag_val(input int which);
    case (which)
      0: return b_operational_in;
      1: return b_address_in;
      2: return b_status_in;
      default: return b_service_in;
    endcase
  endfunction

  // Wait (bounded) for an inbound tag to reach a level.
  task automatic wait_tag(input int which, input logic lvl, input string tag);
    int n;
    n = 0;
    while (tag_val(which) !== lvl && n < 64) begin
      step();
      n++;
    end
    if (tag_val(which) !== lvl) chk({tag, "_timeout"}, {7'd0, tag_val(which)}, {7'd0, lvl});
  endtask

  // Initial selection and command; checks the initial status byte.
  task automatic select_cmd(input logic [7:0] cmd, input logic [7:0] exp_stat);
    b_bus_out = 8'h10; b_operational_out = 1'b1; b_select_out = 1'b1;
    b_hold_out = 1'b1; b_address_out = 1'b1;
    wait_tag(1, 1'b1, "addr_in_up");
    chk("addr_echo", b_bus_in, 8'h10);
    chk("opin_up", {7'd0, b_operational_in}, 8'h01);
    b_address_out = 1'b0; b_bus_out = cmd; b_command_out = 1'b1;
    wait_tag(1, 1'b0, "addr_in_down");
    b_command_out = 1'b0;
    wait_tag(2, 1'b1, "init_stat_up");
    chk("init_status", b_bus_in, exp_stat);
    b_service_out = 1'b1;
    wait_tag(2, 1'b0, "init_stat_down");
    b_service_out = 1'b0;
  endtask

  // One data byte: service_in up with the expected bus value, answer it.
  task automatic data_byte(input logic [7:0] exp_bus, input string tag);
    wait_tag(3, 1'b1, {tag, "_svc_up"});
    chk(tag, b_bus_in, exp_bus);
    b_bus_out = 8'($urandom_range(0, 255));
    b_service_out = 1'b1;
    wait_tag(3, 1'b0, {tag, "_svc_down"});
    b_service_out = 1'b0;
  endtask

  // Ending status CE+DE, then disconnect and deselect.
  task automatic end_status(input string tag);
    wait_tag(2, 1'b1, {tag, "_end_up"});
    chk({tag, "_end_status"}, b_bus_in, 8'h0C);
    b_service_out = 1'b1;
    wait_tag(2, 1'b0, {tag, "_end_down"});
    b_service_out = 1'b0;
    wait_tag(0, 1'b0, {tag, "_opin_down"});
  endtask

  task automatic deselect();
    b_select_out = 1'b0; b_hold_out = 1'b0; b_address_out = 1'b0;
    step(); step();
  endtask

  initial begin
    // Reset state.
    aresetn = 1'b0;
    repeat (3) step();
    chk("rst_opin", {7'd0, b_operational_in}, 8'h00);
    chk("rst_bus", b_bus_in, 8'h00);
    chk("rst_cmd", command, 8'h00);
    chk("rst_count", count, 8'h00);
    chk("rst_state", 8'(dbg_state), 8'(ST_IDLE));
    aresetn = 1'b1;
    step();

    // Address mismatch: selection passes down the chain.
    b_operational_out = 1'b1; b_select_out = 1'b1; b_hold_out = 1'b1;
    b_address_out = 1'b1; b_bus_out = 8'h22;
    step();
    chk("chain_selout", {7'd0, a_select_out}, 8'h01);
    a_select_in = 1'b1;
    step();
    chk("chain_selin", {7'd0, b_select_in}, 8'h01);
    chk("mismatch_opin", {7'd0, b_operational_in}, 8'h00);
    chk("request_in", {7'd0, b_request_in}, 8'h00);
    a_select_in = 1'b0;
    deselect();
    chk("chain_selout_low", {7'd0, a_select_out}, 8'h00);

    // Write 8'h01, three bytes.
    mock_limit = 8'd3;
    select_cmd(8'h01, 8'h00);
    chk("chain_blocked", {7'd0, a_select_out}, 8'h00);
    for (int i = 0; i < 3; i++) data_byte(8'h00, "wr_bus");
    end_status("wr");
    chk("wr_count", count, 8'd3);
    chk("wr_cmd", command, 8'h01);
    deselect();
    chk("wr_idle", 8'(dbg_state), 8'(ST_IDLE));

    // Read 8'h02, two bytes carrying the count.
    mock_limit = 8'd2;
    select_cmd(8'h02, 8'h00);
    data_byte(8'h00, "rd_byte0");
    data_byte(8'h01, "rd_byte1");
    end_status("rd");
    chk("rd_count", count, 8'd2);
    deselect();

    // Busy: status 10, no data phase.
    mock_busy = 1'b1; mock_limit = 8'd3;
    select_cmd(8'h01, 8'h10);
    wait_tag(0, 1'b0, "busy_opin_down");
    chk("busy_svc", {7'd0, b_service_in}, 8'h00);
    chk("busy_cmd", command, 8'h01);
    chk("busy_count", count, 8'h00);
    mock_busy = 1'b0;
    deselect();

    // Zero byte limit: straight to ending status.
    mock_limit = 8'd0;
    select_cmd(8'h01, 8'h00);
    end_status("lim0");
    chk("lim0_count", count, 8'h00);
    deselect();

    // Stop via command_out on the third service_in.
    mock_limit = 8'd5;
    select_cmd(8'h01, 8'h00);
    data_byte(8'h00, "stop_b0");
    data_byte(8'h00, "stop_b1");
    wait_tag(3, 1'b1, "stop_svc_up");
    b_command_out = 1'b1;
    wait_tag(3, 1'b0, "stop_svc_down");
    b_command_out = 1'b0;
    end_status("stop");
    chk("stop_count", count, 8'd2);
    deselect();

    // Selective reset mid-data, then hard reset.
    mock_limit = 8'd5;
    select_cmd(8'h01, 8'h00);
    data_byte(8'h00, "sel_b0");
    wait_tag(3, 1'b1, "sel_svc_up");
    b_operational_out = 1'b0;
    step();
    chk("sel_opin", {7'd0, b_operational_in}, 8'h00);
    chk("sel_svc", {7'd0, b_service_in}, 8'h00);
    chk("sel_stat", {7'd0, b_status_in}, 8'h00);
    chk("sel_bus", b_bus_in, 8'h00);
    chk("sel_state", 8'(dbg_state), 8'(ST_IDLE));
    chk("sel_count_kept", count, 8'd1);
    chk("sel_cmd_kept", command, 8'h01);
    deselect();
    aresetn = 1'b0;
    step();
    chk("hrst_cmd", command, 8'h00);
    chk("hrst_count", count, 8'h00);
    aresetn = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mock_channel_cu.md
Name: mock_channel_cu

Overview:
- Mock IBM parallel-channel (bus-and-tag) control unit for channel-interface bring-up and test.
- Responds to one device address and runs initial selection, command acceptance, byte-interlocked data transfer and ending status.
- Software-controllable busy and byte-limit inputs come from an AXI register wrapper, which also reads back the latched command and the transfer count.
- Passes selection down the select-out/select-in daisy chain when not addressed.

Parameters:
- DEV_ADDR, 8'h10, device address this unit answers to.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with the optional feature.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset.
- b_bus_out  in  8  channel bus out.
- b_bus_in  out  8  bus in to channel.
- b_operational_out, b_hold_out, b_select_out, b_address_out, b_command_out, b_service_out, b_suppress_out  in  1 each  outbound tags.
- b_operational_in, b_request_in, b_select_in, b_address_in, b_status_in, b_service_in  out  1 each  inbound tags.
- a_select_out  out  1  select out to next CU in the chain.
- a_select_in  in  1  select in returned from the chain.
- mock_busy  in  1  answer selection with busy status.
- mock_limit  in  8  data bytes per command.
- command  out  8  last accepted command byte.
- count  out  8  bytes transferred in the current or last command.

Behaviour:
- Clock and reset: aclk; reset aresetn is synchronous, active-low.
- All inputs are already synchronous to aclk. All outputs are registered; each response appears one cycle after the sampled condition.
- Reset values: all inbound tags 0, b_bus_in 0, command 0, count 0, state IDLE.
- Chain passthrough, whenever state is IDLE:
  - a_select_out = b_select_out & b_hold_out.
  - b_select_in = a_select_in.
  - Otherwise a_select_out = 0 and b_select_in = 0.
- b_request_in is constant 0.
- Interlock rule: every inbound tag is raised, held until the channel's response tag rises, dropped, and the next step waits for the response tag to fall.
- FSM states:
  - IDLE: when operational_out & address_out & select_out & hold_out & b_bus_out==DEV_ADDR, raise operational_in and address_in with b_bus_in=DEV_ADDR; go to ADDR.
  - ADDR: on command_out, latch command=b_bus_out, clear count to 0, drop address_in, clear b_bus_in; go to CMD_WAIT.
  - CMD_WAIT: on !command_out, go to INIT_STATUS.
  - INIT_STATUS: raise status_in with b_bus_in = 8'h10 if mock_busy, else 8'h00. On service_out, drop status_in and wait for !service_out. Then branch:
    - busy, or command 8'h00 (test I/O), go to DISCONNECT;
    - control command (cmd[1:0]==2'b11), go to END_STATUS;
    - otherwise go to DATA.
  - DATA: if count==mock_limit, go to END_STATUS. Else raise service_in.
    - Read (cmd[1:0]==2'b10, or cmd[3:0]==4'b0100 sense): b_bus_in = count.
    - Write (cmd[0]==1): on service_out, the byte on b_bus_out is accepted and discarded.
    - On service_out: drop service_in, count <= count+1, wait for !service_out.
    - On command_out while service_in is up (stop): drop service_in, wait for !command_out, go to END_STATUS without incrementing count.
  - END_STATUS: status_in with b_bus_in = 8'h0C (channel end + device end); on service_out, drop status_in; on !service_out, go to DISCONNECT.
  - DISCONNECT: drop operational_in, clear b_bus_in; return to IDLE once select_out is low.
- Boundary rules:
  - mock_limit==0: no data bytes.
  - count is 8-bit and cannot exceed mock_limit, so it never wraps.
  - b_suppress_out is ignored.
  - mock_busy and mock_limit are sampled at INIT_STATUS and in DATA respectively.
- Selective reset: operational_out low in any non-IDLE state returns the unit to IDLE next cycle with all inbound tags and b_bus_in cleared; command and count keep their values.
- aresetn mid-operation clears everything, including command and count.

Optional Feature:
- Macro MOCK_CHANNEL_CU_TIMEOUT_EN.
- When defined: a counter is cleared at every state change. If any non-IDLE state persists TIMEOUT_CYCLES cycles, the unit performs the selective-reset action (IDLE, tags and bus cleared).
- When undefined: there is no counter and the unit waits indefinitely.

Decomposition:
- Package mock_channel_cu_pkg holds:
  - state enum;
  - status constants STAT_BUSY=8'h10, STAT_CE_DE=8'h0C, STAT_ZERO=8'h00;
  - command-class decode function (test I/O, control, read/sense, write).
- One optional sub-module, mock_channel_cu_chain, for the select daisy-chain passthrough. The FSM stays in the top level.

Test Plan:
- Address 8'h22 (mismatch) selection: a_select_out follows b_select_out&hold; a_select_in=1 gives b_select_in=1; operational_in stays 0.
- Address 8'h10, command 8'h01, mock_limit=3: initial status 8'h00, three service_in/out cycles, end status 8'h0C, count=3, command=8'h01, operational_in drops.
- Command 8'h02, mock_limit=2: b_bus_in carries 8'h00 then 8'h01 with service_in; count=2; end status 8'h0C.
- mock_busy=1, command 8'h01: initial status 8'h10, no data phase, disconnect; command=8'h01, count=0.
- Command 8'h01, mock_limit=5, command_out raised on third service_in: stop, count=2, end status 8'h0C.
- operational_out dropped mid-data: next cycle all inbound tags 0 and state IDLE; aresetn low then clears command and count to 0.
